// File: rtl/enc_pwm_mixer_pkg.sv
// ---------------------------------------------------------------------------
// enc_pwm_mixer_pkg
// Shared constants for the encoder/PWM mixer.
//   SAT_WRAP / SAT_CLAMP : values for the SATURATE parameter
//   ch_idx_w()           : width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package enc_pwm_mixer_pkg;

   localparam int SAT_WRAP  = 0;
   localparam int SAT_CLAMP = 1;

   // A single channel still needs a 1-bit index port.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/enc_pwm_mixer_if.sv
// ---------------------------------------------------------------------------
// enc_pwm_mixer_if
// Pin bundle of the mixer as seen from the Caravel wrapper.
//   enc_a, enc_b : per-channel quadrature inputs (asynchronous)
//   load_en      : one-cycle strobe writing load_val into channel load_ch
//   load_ch      : channel index for the load
//   load_val     : value to load
//   level        : packed channel levels, channel i at [i*WIDTH +: WIDTH]
//   pwm_out      : registered PWM output per channel
// master = environment driving the mixer, slave = the mixer itself.
// ---------------------------------------------------------------------------
interface enc_pwm_mixer_if #(
   parameter int NUM_CH = 3,
   parameter int WIDTH  = 8
) ();
   import enc_pwm_mixer_pkg::*;

   localparam int IDX_W = ch_idx_w(NUM_CH);

   logic [NUM_CH-1:0]        enc_a;
   logic [NUM_CH-1:0]        enc_b;
   logic                     load_en;
   logic [IDX_W-1:0]         load_ch;
   logic [WIDTH-1:0]         load_val;
   logic [NUM_CH*WIDTH-1:0]  level;
   logic [NUM_CH-1:0]        pwm_out;

   modport master (
      output enc_a, enc_b, load_en, load_ch, load_val,
      input  level, pwm_out
   );

   modport slave (
      input  enc_a, enc_b, load_en, load_ch, load_val,
      output level, pwm_out
   );

endinterface

// File: rtl/enc_pwm_mixer_enc_channel.sv
// ---------------------------------------------------------------------------
// enc_channel
// One mixer channel: 2-flop synchroniser and debouncer on each encoder
// phase, x1 decode on rising edges of debounced A, and the level counter
// with direct load and saturate/wrap arithmetic.
//   clk, resetb : clock, asynchronous active-low reset
//   a, b        : raw encoder phases (asynchronous)
//   load        : write load_val into the level this cycle (wins over a step)
//   load_val    : value to load
//   level       : current level
// ---------------------------------------------------------------------------
module enc_channel
   import enc_pwm_mixer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 4,
   parameter int SATURATE  = SAT_CLAMP
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             a,
   input  logic             b,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] level
);

   // Debounce counter only has to reach DB_CYCLES-1; the next differing
   // sample is the one that commits the new stable value.
   localparam int             CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

   // Index 0 = phase A, index 1 = phase B.
   logic [1:0]         sync1_q, sync2_q;
   logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]         stable_q, stable_d;
   logic               a_prev_q;
   logic [WIDTH-1:0]   level_q, level_d;
   logic               a_rise;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value; blocking here would collapse the
   // two synchroniser stages into one.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_cnt_q <= '0;
         stable_q <= '0;
         a_prev_q <= 1'b0;
         level_q  <= '0;
      end else begin
         sync1_q  <= {b, a};
         sync2_q  <= sync1_q;
         db_cnt_q <= db_cnt_d;
         stable_q <= stable_d;
         a_prev_q <= stable_q[0];
         level_q  <= level_d;
      end
   end

   // Debounce: a change is accepted after DB_CYCLES consecutive differing
   // samples; any agreeing sample restarts the count.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise
      // the missing branches would infer latches.
      db_cnt_d = db_cnt_q;
      stable_d = stable_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
   end

   assign a_rise = stable_q[0] & ~a_prev_q;

   // Level update: load beats a step; B low counts up, B high counts down.
   always_comb begin
      level_d = level_q;
      if (load) begin
         level_d = load_val;
      end else if (a_rise) begin
         if (!stable_q[1]) begin
            if (!(SATURATE == SAT_CLAMP && level_q == '1)) level_d = level_q + 1'b1;
         end else begin
            if (!(SATURATE == SAT_CLAMP && level_q == '0)) level_d = level_q - 1'b1;
         end
      end
   end

   assign level = level_q;

endmodule

// File: rtl/enc_pwm_mixer.sv
// ---------------------------------------------------------------------------
// enc_pwm_mixer
// NUM_CH encoder-driven level counters, each driving a PWM output compared
// against one shared free-running counter.
//   clk    : system clock
//   resetb : asynchronous active-low reset
//   bus    : mixer pins (encoders, LA load port, levels, PWM outputs)
// ---------------------------------------------------------------------------
module enc_pwm_mixer
   import enc_pwm_mixer_pkg::*;
#(
   parameter int NUM_CH    = 3,
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 4,
   parameter int SATURATE  = SAT_CLAMP
) (
   input  logic           clk,
   input  logic           resetb,
   enc_pwm_mixer_if.slave bus
);

   localparam int IDX_W = ch_idx_w(NUM_CH);

   logic [NUM_CH-1:0][WIDTH-1:0] level_w;
   logic [NUM_CH-1:0]            load_hit;
   logic [WIDTH-1:0]             pwm_cnt_q, pwm_cnt_d;
   logic [NUM_CH-1:0]            pwm_q, pwm_d;

   // An out-of-range load_ch matches no channel, so the load is dropped.
   always_comb begin
      load_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         load_hit[i] = bus.load_en && (bus.load_ch == IDX_W'(i));
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      enc_channel #(
         .WIDTH     (WIDTH),
         .DB_CYCLES (DB_CYCLES),
         .SATURATE  (SATURATE)
      ) u_ch (
         .clk      (clk),
         .resetb   (resetb),
         .a        (bus.enc_a[i]),
         .b        (bus.enc_b[i]),
         .load     (load_hit[i]),
         .load_val (bus.load_val),
         .level    (level_w[i])
      );
   end

   // Level L is high for counter values 0..L-1, i.e. L cycles per period.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      pwm_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pwm_d[i] = (pwm_cnt_q < level_w[i]);
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pwm_cnt_q <= '0;
         pwm_q     <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         pwm_q     <= pwm_d;
      end
   end

   assign bus.level   = level_w;
   assign bus.pwm_out = pwm_q;

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// ---------------------------------------------------------------------------
// tb_enc_pwm_mixer
// Directed bench for enc_pwm_mixer (NUM_CH=3, WIDTH=8, DB_CYCLES=4).
// dut_s saturates, dut_w wraps; both receive identical stimulus.
// ---------------------------------------------------------------------------
module tb_enc_pwm_mixer;

   localparam int NUM_CH    = 3;
   localparam int WIDTH     = 8;
   localparam int DB_CYCLES = 4;

   logic clk    = 1'b0;
   logic resetb = 1'b0;

   always #5 clk = ~clk;

   enc_pwm_mixer_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus_s ();
   enc_pwm_mixer_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus_w ();

   enc_pwm_mixer #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DB_CYCLES(DB_CYCLES), .SATURATE(1)
   ) dut_s (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus_s.slave)
   );

   enc_pwm_mixer #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DB_CYCLES(DB_CYCLES), .SATURATE(0)
   ) dut_w (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus_w.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_enc(input logic [2:0] a, input logic [2:0] b);
      bus_s.enc_a = a;
      bus_s.enc_b = b;
      bus_w.enc_a = a;
      bus_w.enc_b = b;
   endtask

   task automatic set_load(input logic en, input logic [1:0] ch, input logic [7:0] val);
      bus_s.load_en  = en;
      bus_s.load_ch  = ch;
      bus_s.load_val = val;
      bus_w.load_en  = en;
      bus_w.load_ch  = ch;
      bus_w.load_val = val;
   endtask

   task automatic load(input logic [1:0] ch, input logic [7:0] val);
      set_load(1'b1, ch, val);
      @(negedge clk);
      set_load(1'b0, 2'd0, 8'd0);
   endtask

   // One full encoder pulse on the channels in a_mask; b gives direction.
   task automatic pulse(input logic [2:0] a_mask, input logic [2:0] b);
      drive_enc(3'b000, b);
      cycles(10);
      drive_enc(a_mask, b);
      cycles(10);
      drive_enc(3'b000, b);
      cycles(10);
   endtask

   function automatic int lvl_s(input int ch);
      return int'(bus_s.level[ch*WIDTH +: WIDTH]);
   endfunction

   function automatic int lvl_w(input int ch);
      return int'(bus_w.level[ch*WIDTH +: WIDTH]);
   endfunction

   // High cycles of pwm_out[ch] over one full 256-cycle period.
   task automatic pwm_high(input int ch, output int hs, output int hw);
      hs = 0;
      hw = 0;
      repeat (256) begin
         @(negedge clk);
         hs += int'(bus_s.pwm_out[ch]);
         hw += int'(bus_w.pwm_out[ch]);
      end
   endtask

   int hs, hw, bad;
   int exp_s [3];
   int exp_w [3];
   logic [2:0] dirs [4];

   initial begin
      drive_enc(3'b000, 3'b000);
      set_load(1'b0, 2'd0, 8'd0);

      // 1. reset then quiet
      cycles(5);
      check("reset_level", int'(bus_s.level), 0);
      check("reset_pwm", int'(bus_s.pwm_out), 0);
      resetb = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (bus_s.level != '0 || bus_s.pwm_out != '0 ||
             bus_w.level != '0 || bus_w.pwm_out != '0) bad++;
      end
      check("quiet_window", bad, 0);

      // 2. increment, latency, PWM duty
      drive_enc(3'b001, 3'b000);
      repeat (6) @(negedge clk);
      check("latency_edge6", lvl_s(0), 0);
      @(negedge clk);
      check("latency_edge7", lvl_s(0), 1);
      cycles(3);
      drive_enc(3'b000, 3'b000);
      cycles(10);
      repeat (9) pulse(3'b001, 3'b000);
      check("inc_to_10", lvl_s(0), 10);
      pwm_high(0, hs, hw);
      check("pwm_duty_10", hs, 10);

      // 3. bounce rejection on channel 1
      for (int t = 0; t < 20; t++) begin
         drive_enc({1'b0, ~bus_s.enc_a[1], 1'b0}, 3'b000);
         cycles(2);
      end
      check("bounce_end", lvl_s(1), 0);
      cycles(20);
      check("bounce_settled", lvl_s(1), 0);

      // 4. saturate vs wrap
      load(2'd0, 8'd0);
      check("load_zero", lvl_s(0), 0);
      pulse(3'b001, 3'b001);
      check("sat_floor", lvl_s(0), 0);
      check("wrap_under", lvl_w(0), 255);
      load(2'd0, 8'd255);
      pulse(3'b001, 3'b000);
      check("sat_ceil", lvl_s(0), 255);
      check("wrap_over", lvl_w(0), 0);
      pwm_high(0, hs, hw);
      check("pwm_duty_255", hs, 255);
      check("pwm_duty_0", hw, 0);

      // 5. load priority and out-of-range load
      load(2'd2, 8'd50);
      load(2'd0, 8'd20);
      cycles(10);
      drive_enc(3'b101, 3'b000);
      repeat (6) @(negedge clk);
      set_load(1'b1, 2'd2, 8'd128);
      @(negedge clk);
      set_load(1'b0, 2'd0, 8'd0);
      check("load_prio_s", lvl_s(2), 128);
      check("load_prio_w", lvl_w(2), 128);
      check("other_step_s", lvl_s(0), 21);
      check("other_step_w", lvl_w(0), 21);
      cycles(3);
      drive_enc(3'b000, 3'b000);
      cycles(10);
      load(2'd3, 8'd77);
      cycles(2);
      check("oor_ch0", lvl_s(0), 21);
      check("oor_ch1", lvl_s(1), 0);
      check("oor_ch2", lvl_s(2), 128);

      // 6. concurrent multichannel sequence against a model, then reset
      load(2'd0, 8'd254);
      load(2'd1, 8'd1);
      load(2'd2, 8'd100);
      exp_s = '{254, 1, 100};
      exp_w = '{254, 1, 100};
      dirs  = '{3'b010, 3'b110, 3'b010, 3'b011};
      for (int k = 0; k < 4; k++) begin
         pulse(3'b111, dirs[k]);
         for (int c = 0; c < 3; c++) begin
            if (dirs[k][c]) begin
               exp_s[c] = (exp_s[c] == 0) ? 0 : exp_s[c] - 1;
               exp_w[c] = (exp_w[c] + 255) % 256;
            end else begin
               exp_s[c] = (exp_s[c] == 255) ? 255 : exp_s[c] + 1;
               exp_w[c] = (exp_w[c] + 1) % 256;
            end
         end
      end
      for (int c = 0; c < 3; c++) begin
         check($sformatf("multi_s_ch%0d", c), lvl_s(c), exp_s[c]);
         check($sformatf("multi_w_ch%0d", c), lvl_w(c), exp_w[c]);
      end

      drive_enc(3'b000, 3'b000);
      cycles(10);
      drive_enc(3'b111, 3'b000);
      cycles(3);
      resetb = 1'b0;
      #1;
      check("rst_mid_level_s", int'(bus_s.level), 0);
      check("rst_mid_level_w", int'(bus_w.level), 0);
      check("rst_mid_pwm_s", int'(bus_s.pwm_out), 0);
      check("rst_mid_pwm_w", int'(bus_w.pwm_out), 0);
      cycles(3);
      check("rst_hold_level", int'(bus_s.level), 0);
      resetb = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_edge6", int'(bus_s.level), 0);
      @(negedge clk);
      check("post_rst_edge7_s", int'(bus_s.level), 32'h010101);
      check("post_rst_edge7_w", int'(bus_w.level), 32'h010101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
